// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM state encoding and port indices.
package dmem_port_arbiter_pkg;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_FORCE1 = 1'b1
  } arb_state_e;

  localparam int unsigned PORT0 = 0;
  localparam int unsigned PORT1 = 1;
  localparam int unsigned WAIT_W = 4;

endpackage

// File: rtl/dmem_arb_return.sv
// Per-port registered read return: captures memory read data at the end of a read grant.
module dmem_arb_return #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gnt,
  input  logic          we,
  input  logic          aligned,
  input  logic [DW-1:0] mem_rd,
  output logic          rvalid,
  output logic [DW-1:0] rdata
);

  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;

  always_comb begin
    rvalid_d = gnt & ~we;
    rdata_d  = rdata_q;
    // Misaligned reads complete the handshake but return zero.
    if (gnt && !we) rdata_d = aligned ? mem_rd : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for the single-port data memory: port 0 priority with bounded wait for port 1.
// Optional DMEM_ARB_STATS_EN adds saturating grant/stall counters and their output ports.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          stall0,
  output logic          misalign,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]   grant_cnt0,
  output logic [31:0]   grant_cnt1,
  output logic [31:0]   stall_cnt0
`endif
);

  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT - 1);

  arb_state_e        state_q, state_d, state_eff;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        gnt;
  logic              sel_we, aligned, misalign_q, misalign_d;

  // During reset the grant decision behaves as NORMAL so outputs follow the requests only.
  assign state_eff = RST ? ARB_NORMAL : state_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ARB_NORMAL;
      wait_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    wait_d = '0;
    if (req1 && !gnt[PORT1]) wait_d = (wait_q == '1) ? wait_q : wait_q + 1'b1;
    state_d = state_q;
    unique case (state_q)
      ARB_NORMAL: if (req1 && !gnt[PORT1] && wait_d >= WAIT_LIM) state_d = ARB_FORCE1;
      ARB_FORCE1: if (gnt[PORT1] || !req1) state_d = ARB_NORMAL;
      default:    state_d = ARB_NORMAL;
    endcase
  end

  always_comb begin
    gnt = '0;
    unique case (state_eff)
      ARB_FORCE1: begin
        if (req1)      gnt[PORT1] = 1'b1;
        else if (req0) gnt[PORT0] = 1'b1;
      end
      default: begin
        if (req0)      gnt[PORT0] = 1'b1;
        else if (req1) gnt[PORT1] = 1'b1;
      end
    endcase
  end

  always_comb begin
    mem_addr   = gnt[PORT1] ? addr1  : addr0;
    mem_wdata  = gnt[PORT1] ? wdata1 : wdata0;
    sel_we     = gnt[PORT1] ? we1    : we0;
    aligned    = (mem_addr[1:0] == 2'b00);
    mem_we     = (|gnt) & sel_we & aligned;
    misalign_d = (|gnt) & ~aligned;
  end

  assign gnt0     = gnt[PORT0];
  assign gnt1     = gnt[PORT1];
  assign stall0   = req0 & ~gnt[PORT0];
  assign misalign = misalign_q;

  dmem_arb_return #(.DW(DW)) u_ret0 (
    .clk(CLK), .rst(RST), .gnt(gnt[PORT0]), .we(we0), .aligned(aligned),
    .mem_rd(mem_rd), .rvalid(rvalid0), .rdata(rdata0)
  );

  dmem_arb_return #(.DW(DW)) u_ret1 (
    .clk(CLK), .rst(RST), .gnt(gnt[PORT1]), .we(we1), .aligned(aligned),
    .mem_rd(mem_rd), .rvalid(rvalid1), .rdata(rdata1)
  );

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] gcnt0_q, gcnt0_d, gcnt1_q, gcnt1_d, scnt0_q, scnt0_d;

  always_comb begin
    gcnt0_d = (gnt[PORT0] && gcnt0_q != '1) ? gcnt0_q + 32'd1 : gcnt0_q;
    gcnt1_d = (gnt[PORT1] && gcnt1_q != '1) ? gcnt1_q + 32'd1 : gcnt1_q;
    scnt0_d = (stall0     && scnt0_q != '1) ? scnt0_q + 32'd1 : scnt0_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
      scnt0_q <= '0;
    end else begin
      gcnt0_q <= gcnt0_d;
      gcnt1_q <= gcnt1_d;
      scnt0_q <= scnt0_d;
    end
  end

  assign grant_cnt0 = gcnt0_q;
  assign grant_cnt1 = gcnt1_q;
  assign stall_cnt0 = scnt0_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: single-cycle vector table plus multi-cycle sequences.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, stall0, misalign, mem_we;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rd;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] grant_cnt0, grant_cnt1, stall_cnt0;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [31:0] mem [64];

  always #5 clk = ~clk;

  // Memory model: combinational read, write committed on the falling edge.
  assign mem_rd = mem[mem_addr[7:2]];
  always @(negedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  dmem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
    .CLK(clk), .RST(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .stall0(stall0), .misalign(misalign),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rd(mem_rd)
`ifdef DMEM_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .stall_cnt0(stall_cnt0)
`endif
  );

  typedef struct {
    logic        r0, r1, w0, w1;
    logic [31:0] a0, a1, d0, d1;
    logic        g0, g1, st, mwe;
    logic [31:0] maddr, mwdata;
    logic        rv0, rv1, mis;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
  endtask

  task automatic drv(input logic r0, input logic r1, input logic w0, input logic w1,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input logic [31:0] d0, input logic [31:0] d1);
    req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst = 1'b1;
    drv(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);

    vecs[0] = '{1'b1,1'b0,1'b0,1'b0, 32'h10,32'h0,32'h0,32'h0, 1'b1,1'b0,1'b0,1'b0, 32'h10,32'h0, 1'b1,1'b0,1'b0};
    vecs[1] = '{1'b0,1'b1,1'b0,1'b0, 32'h0,32'h20,32'h0,32'h0, 1'b0,1'b1,1'b0,1'b0, 32'h20,32'h0, 1'b0,1'b1,1'b0};
    vecs[2] = '{1'b1,1'b1,1'b0,1'b0, 32'h30,32'h34,32'h0,32'h0, 1'b1,1'b0,1'b0,1'b0, 32'h30,32'h0, 1'b1,1'b0,1'b0};
    vecs[3] = '{1'b1,1'b0,1'b1,1'b0, 32'h40,32'h0,32'hCAFEF00D,32'h0, 1'b1,1'b0,1'b0,1'b1, 32'h40,32'hCAFEF00D, 1'b0,1'b0,1'b0};
    vecs[4] = '{1'b0,1'b1,1'b0,1'b1, 32'h0,32'h22,32'h0,32'hFFFF, 1'b0,1'b1,1'b0,1'b0, 32'h22,32'hFFFF, 1'b0,1'b0,1'b1};
    vecs[5] = '{1'b1,1'b0,1'b0,1'b0, 32'h13,32'h0,32'h0,32'h0, 1'b1,1'b0,1'b0,1'b0, 32'h13,32'h0, 1'b1,1'b0,1'b1};
    vecs[6] = '{1'b0,1'b0,1'b1,1'b0, 32'h44,32'h48,32'h11111111,32'h0, 1'b0,1'b0,1'b0,1'b0, 32'h44,32'h11111111, 1'b0,1'b0,1'b0};
    vecs[7] = '{1'b1,1'b1,1'b0,1'b1, 32'h4C,32'h48,32'h0,32'h22222222, 1'b1,1'b0,1'b0,1'b0, 32'h4C,32'h0, 1'b1,1'b0,1'b0};

    step(); step();
    rst = 1'b0;
    #3;
    chk("rst_rvalid0", 32'(rvalid0), 32'h0);
    chk("rst_rvalid1", 32'(rvalid1), 32'h0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_misalign", 32'(misalign), 32'h0);

    // Single-cycle vectors, each separated by an idle cycle.
    for (int v = 0; v < 8; v++) begin
      step();
      drv(vecs[v].r0, vecs[v].r1, vecs[v].w0, vecs[v].w1,
          vecs[v].a0, vecs[v].a1, vecs[v].d0, vecs[v].d1);
      #3;
      chk($sformatf("v%0d_gnt0", v), 32'(gnt0), 32'(vecs[v].g0));
      chk($sformatf("v%0d_gnt1", v), 32'(gnt1), 32'(vecs[v].g1));
      chk($sformatf("v%0d_stall0", v), 32'(stall0), 32'(vecs[v].st));
      chk($sformatf("v%0d_mem_we", v), 32'(mem_we), 32'(vecs[v].mwe));
      chk($sformatf("v%0d_mem_addr", v), mem_addr, vecs[v].maddr);
      chk($sformatf("v%0d_mem_wdata", v), mem_wdata, vecs[v].mwdata);
      step();
      idle();
      #3;
      chk($sformatf("v%0d_rvalid0", v), 32'(rvalid0), 32'(vecs[v].rv0));
      chk($sformatf("v%0d_rvalid1", v), 32'(rvalid1), 32'(vecs[v].rv1));
      chk($sformatf("v%0d_misalign", v), 32'(misalign), 32'(vecs[v].mis));
    end

    // Port 0 write then read of 0x10.
    step(); drv(1, 0, 1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0); #3;
    chk("a_wr_mem_we", 32'(mem_we), 32'h1);
    step(); drv(1, 0, 0, 0, 32'h10, 32'h0, 32'h0, 32'h0); #3;
    chk("a_rd_gnt0", 32'(gnt0), 32'h1);
    chk("a_wr_no_rvalid", 32'(rvalid0), 32'h0);
    step(); idle(); #3;
    chk("a_rvalid0", 32'(rvalid0), 32'h1);
    chk("a_rdata0", rdata0, 32'hDEADBEEF);
    step(); #3;
    chk("a_rvalid0_pulse", 32'(rvalid0), 32'h0);
    chk("a_rdata0_hold", rdata0, 32'hDEADBEEF);

    // Port 1 write 0x1234 to 0x20 then read it back the next cycle.
    step(); drv(0, 1, 0, 1, 32'h0, 32'h20, 32'h0, 32'h1234); #3;
    chk("b_wr_gnt1", 32'(gnt1), 32'h1);
    step(); drv(0, 1, 0, 0, 32'h0, 32'h20, 32'h0, 32'h0); #3;
    step(); idle(); #3;
    chk("b_rvalid1", 32'(rvalid1), 32'h1);
    chk("b_rdata1", rdata1, 32'h1234);

    // Misaligned write leaves memory unchanged.
    step(); drv(0, 1, 0, 1, 32'h0, 32'h22, 32'h0, 32'hFFFFFFFF); #3;
    chk("d_gnt1", 32'(gnt1), 32'h1);
    chk("d_mem_we", 32'(mem_we), 32'h0);
    step(); idle(); #3;
    chk("d_misalign", 32'(misalign), 32'h1);
    chk("d_no_rvalid1", 32'(rvalid1), 32'h0);
    step(); drv(0, 1, 0, 0, 32'h0, 32'h20, 32'h0, 32'h0); #3;
    chk("d_misalign_pulse", 32'(misalign), 32'h0);
    step(); idle(); #3;
    chk("d_mem_unchanged", rdata1, 32'h1234);

    // Misaligned read returns zero with rvalid.
    step(); drv(1, 0, 0, 0, 32'h11, 32'h0, 32'h0, 32'h0); #3;
    step(); idle(); #3;
    chk("e_rvalid0", 32'(rvalid0), 32'h1);
    chk("e_rdata0_zero", rdata0, 32'h0);
    chk("e_misalign", 32'(misalign), 32'h1);

    // Partial contention, then reset with a read grant in flight.
    step(); drv(1, 1, 0, 0, 32'h10, 32'h20, 32'h0, 32'h0); #3;
    chk("f_gnt0_c0", 32'(gnt0), 32'h1);
    step(); #3;
    chk("f_gnt0_c1", 32'(gnt0), 32'h1);
    chk("f_rdata0_pre", rdata0, 32'hDEADBEEF);
    step(); rst = 1'b1; #3;
    chk("f_rst_gnt0", 32'(gnt0), 32'h1);
    chk("f_rst_gnt1", 32'(gnt1), 32'h0);
    step(); rst = 1'b0; #3;
    chk("f_rvalid0", 32'(rvalid0), 32'h0);
    chk("f_rdata0", rdata0, 32'h0);
    chk("f_misalign", 32'(misalign), 32'h0);

    // Full contention from a clean reset: three port-0 grants, then port 1.
    for (int k = 0; k < 8; k++) begin
      if (k != 0) begin step(); #3; end
      chk($sformatf("c%0d_gnt0", k), 32'(gnt0), (k == 3 || k == 7) ? 32'h0 : 32'h1);
      chk($sformatf("c%0d_gnt1", k), 32'(gnt1), (k == 3 || k == 7) ? 32'h1 : 32'h0);
      chk($sformatf("c%0d_stall0", k), 32'(stall0), (k == 3 || k == 7) ? 32'h1 : 32'h0);
    end
    step(); idle(); #3;
    chk("c_rvalid1", 32'(rvalid1), 32'h1);
    chk("c_rdata1", rdata1, 32'h1234);
`ifdef DMEM_ARB_STATS_EN
    chk("s_grant_cnt0", grant_cnt0, 32'd6);
    chk("s_grant_cnt1", grant_cnt1, 32'd2);
    chk("s_stall_cnt0", stall_cnt0, 32'd2);
`endif

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
